// File: rtl/aes_inv_round_engine.sv
// Iterative AES decryption core: one inverse-round datapath (AddRoundKey, InvMixColumns,
// InvShiftRows/InvSubBytes) is reused for every round, with the key read from an external RAM.
module aes_inv_round_engine #(
  parameter int NUM_ROUNDS     = 10,
  parameter int COLS_PER_CYCLE = 4,
  parameter int KEY_IDX_W      = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [0:127]         in_data,
  output logic [KEY_IDX_W-1:0] key_idx,
  input  logic [0:127]         round_key,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [0:127]         out_data,
  output logic                 busy
);
  localparam int M     = 4 / COLS_PER_CYCLE;
  localparam int RND_W = $clog2(NUM_ROUNDS + 1);
  localparam logic [KEY_IDX_W-1:0] KEY_LAST  = KEY_IDX_W'(NUM_ROUNDS);
  localparam logic [RND_W-1:0]     RND_LAST  = RND_W'(NUM_ROUNDS);
  localparam logic [1:0]           MCOL_LAST = 2'(M - 1);

  typedef enum logic [2:0] {S_IDLE, S_KEY, S_ARK, S_MIX, S_SUB, S_OUT} state_t;

  state_t             state_q, state_d;
  logic [0:127]       st_q;
  logic [RND_W-1:0]   rnd_q;
  logic [1:0]         mcol_q;
  logic [0:127]       mix_st, sub_st;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse affine map, then x^254 which is the field inverse (and maps 0 to 0).
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b, sq, r;
    b  = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    sq = b;
    r  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  // Only COLS_PER_CYCLE mixers exist; they walk across the state one group per cycle.
  always_comb begin
    mix_st = st_q;
    for (int j = 0; j < COLS_PER_CYCLE; j++)
      mix_st[32*(int'(mcol_q)*COLS_PER_CYCLE + j) +: 32] =
        inv_mix_col(st_q[32*(int'(mcol_q)*COLS_PER_CYCLE + j) +: 32]);
  end

  // Byte (r,c) sits at index r+4c; row r rotates right by r.
  always_comb begin
    sub_st = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sub_st[8*(r+4*c) +: 8] = inv_sbox(st_q[8*(r+4*((c+4-r)%4)) +: 8]);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = S_KEY;
      S_KEY:  state_d = S_ARK;
      S_ARK: begin
        if (rnd_q == RND_LAST)  state_d = S_OUT;
        else if (rnd_q == '0)   state_d = S_SUB;
        else                    state_d = S_MIX;
      end
      S_MIX:  if (mcol_q == MCOL_LAST) state_d = S_SUB;
      S_SUB:  state_d = S_KEY;
      S_OUT:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      st_q     <= '0;
      rnd_q    <= '0;
      mcol_q   <= '0;
      key_idx  <= KEY_LAST;
      out_data <= '0;
    end else if (abort && state_q != S_IDLE) begin
      key_idx <= KEY_LAST;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          st_q    <= in_data;
          rnd_q   <= '0;
          key_idx <= KEY_LAST;
        end
        S_ARK: begin
          st_q   <= st_q ^ round_key;
          mcol_q <= '0;
          if (rnd_q == RND_LAST) out_data <= st_q ^ round_key;
        end
        S_MIX: begin
          st_q   <= mix_st;
          mcol_q <= mcol_q + 2'd1;
        end
        S_SUB: begin
          st_q    <= sub_st;
          rnd_q   <= rnd_q + RND_W'(1);
          key_idx <= KEY_LAST - KEY_IDX_W'(rnd_q) - KEY_IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_OUT);

endmodule

// File: tb/tb_aes_inv_round_engine.sv
// Bench for aes_inv_round_engine: four instances (Nr/cols = 10/4, 10/1, 14/4, 12/2) fed from a
// behavioural key RAM, checked against FIPS-197 vectors and a forward AES encryption model.
module tb_aes_inv_round_engine;
  localparam int NI = 4;
  localparam logic [0:127] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] C2_CT = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [0:127] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;

  function automatic int nr_of(input int i);
    return (i == 2) ? 14 : (i == 3) ? 12 : 10;
  endfunction
  function automatic int cpc_of(input int i);
    return (i == 1) ? 1 : (i == 3) ? 2 : 4;
  endfunction

  logic         Clk = 1'b0;
  logic         Reset;
  logic         abort [NI];
  logic         in_valid [NI];
  logic         in_ready [NI];
  logic [0:127] in_data [NI];
  logic [3:0]   key_idx [NI];
  logic [0:127] round_key [NI];
  logic         out_valid [NI];
  logic         out_ready [NI];
  logic [0:127] out_data [NI];
  logic         busy [NI];
  logic [0:127] rk [NI][16];

  int checks = 0;
  int errors = 0;
  int stab_err = 0;
  int kseq [512];

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    aes_inv_round_engine #(
      .NUM_ROUNDS(nr_of(g)), .COLS_PER_CYCLE(cpc_of(g)), .KEY_IDX_W(4)
    ) u_dut (
      .Clk(Clk), .Reset(Reset), .abort(abort[g]),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_data(in_data[g]),
      .key_idx(key_idx[g]), .round_key(round_key[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_data(out_data[g]),
      .busy(busy[g])
    );
  end

  // Key RAM with one cycle of read latency.
  always_ff @(posedge Clk)
    for (int g = 0; g < NI; g++) round_key[g] <= rk[g][key_idx[g]];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Forward AES reference model
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq = x; inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gm(sq, sq);
      inv = gm(inv, sq);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  task automatic expand(input int i, input logic [0:255] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int k = 0; k < nk; k++) w[k] = key[32*k +: 32];
    for (int k = nk; k < 4*(nr+1); k++) begin
      t = w[k-1];
      if (k % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && k % nk == 4) begin
        t = subw(t);
      end
      w[k] = w[k-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk[i][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [0:127] encrypt(input int i, input logic [0:127] pt);
    logic [0:127] s, t;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ rk[i][0];
    for (int r = 1; r <= nr_of(i); r++) begin
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          t[8*(w+4*c) +: 8] = sbox(s[8*(w+4*((c+w)%4)) +: 8]);
      if (r < nr_of(i))
        for (int c = 0; c < 4; c++) begin
          {a0, a1, a2, a3} = t[32*c +: 32];
          t[32*c +: 32] = {gm(a0,8'h02)^gm(a1,8'h03)^a2^a3, a0^gm(a1,8'h02)^gm(a2,8'h03)^a3,
                           a0^a1^gm(a2,8'h02)^gm(a3,8'h03), gm(a0,8'h03)^a1^a2^gm(a3,8'h02)};
        end
      s = t ^ rk[i][r];
    end
    return s;
  endfunction

  task automatic check_reset(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s_in_ready%0d", tag, i), in_ready[i], 1'b1);
      chk($sformatf("%s_out_valid%0d", tag, i), out_valid[i], 1'b0);
      chk($sformatf("%s_busy%0d", tag, i), busy[i], 1'b0);
      chk($sformatf("%s_key_idx%0d", tag, i), key_idx[i], 128'(nr_of(i)));
      chk($sformatf("%s_out_data%0d", tag, i), out_data[i], 128'h0);
    end
  endtask

  // Called just after a rising edge; returns just after the acceptance edge.
  task automatic start_block(input int i, input logic [0:127] ct);
    int n;
    n = 0;
    in_data[i]  = ct;
    in_valid[i] = 1'b1;
    @(negedge Clk);
    while (!in_ready[i] && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (!in_ready[i]) chk("accept_timeout", in_ready[i], 1'b1);
    @(posedge Clk); #1;
    in_valid[i] = 1'b0;
    kseq[0] = int'(key_idx[i]);
  endtask

  task automatic wait_valid(input int i, output int lat, output logic [0:127] res);
    lat = 0;
    while (!out_valid[i] && lat < 400) begin
      @(posedge Clk); #1;
      lat++;
      kseq[lat] = int'(key_idx[i]);
    end
    if (!out_valid[i]) chk("valid_timeout", out_valid[i], 1'b1);
    res = out_data[i];
  endtask

  task automatic finish_block(input int i, input bit stall);
    int n;
    bit hs;
    logic [0:127] hold;
    n = 0; hs = 1'b0; hold = out_data[i];
    while (!hs && n < 200) begin
      if (stall) out_ready[i] = ($urandom_range(0, 2) != 0);
      hs = out_ready[i] && out_valid[i];
      @(posedge Clk); #1;
      n++;
      if (!hs && (out_valid[i] !== 1'b1 || out_data[i] !== hold)) stab_err++;
    end
    out_ready[i] = 1'b1;
    if (!hs) chk("handshake_timeout", hs, 1'b1);
  endtask

  task automatic run(input int i, input logic [0:127] ct, input bit stall,
                     output logic [0:127] res, output int lat);
    start_block(i, ct);
    wait_valid(i, lat, res);
    finish_block(i, stall);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:127] res, pt, ct;
    int lat, kerr, e1, e2, e3, cnt, ke;
    Reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      abort[i] = 1'b0; in_valid[i] = 1'b0; in_data[i] = '0; out_ready[i] = 1'b1;
      for (int r = 0; r < 16; r++) rk[i][r] = '0;
    end
    expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    expand(1, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    expand(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
    expand(3, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
    #22;
    check_reset("rst");
    Reset = 1'b0;
    @(posedge Clk); #1;

    run(0, C1_CT, 1'b0, res, lat);
    chk("c1_data", res, PT);
    chk("c1_lat", lat, 41);
    chk("c1_idle_in_ready", in_ready[0], 1'b1);
    chk("c1_idle_out_valid", out_valid[0], 1'b0);

    run(1, C1_CT, 1'b0, res, lat);
    chk("c1_cols1_data", res, PT);
    chk("c1_cols1_lat", lat, 68);
    kerr = 0;
    for (int k = 0; k <= 68; k++) begin
      ke = (k < 3) ? 10 : 9 - (k - 3) / 7;
      if (ke < 0) ke = 0;
      if (kseq[k] != ke) kerr++;
    end
    chk("key_seq_mismatches", kerr, 0);

    run(2, C3_CT, 1'b0, res, lat);
    chk("c3_data", res, PT);
    chk("c3_lat", lat, 57);
    run(3, C2_CT, 1'b0, res, lat);
    chk("c2_data", res, PT);
    chk("c2_lat", lat, 60);

    // Output backpressure
    out_ready[0] = 1'b0;
    start_block(0, C1_CT);
    wait_valid(0, lat, res);
    e1 = 0; e2 = 0; e3 = 0;
    repeat (20) begin
      @(posedge Clk); #1;
      if (out_valid[0] !== 1'b1) e1++;
      if (out_data[0] !== res) e2++;
      if (in_ready[0] !== 1'b0) e3++;
    end
    chk("stall_data", res, PT);
    chk("stall_valid_drops", e1, 0);
    chk("stall_data_changes", e2, 0);
    chk("stall_in_ready_high", e3, 0);
    out_ready[0] = 1'b1;
    @(posedge Clk); #1;
    chk("release_out_valid", out_valid[0], 1'b0);
    chk("release_in_ready", in_ready[0], 1'b1);
    in_data[0] = C1_CT; in_valid[0] = 1'b1;
    @(posedge Clk); #1;
    in_valid[0] = 1'b0;
    chk("release_accept_busy", busy[0], 1'b1);
    wait_valid(0, lat, res);
    finish_block(0, 1'b0);
    chk("release_next_data", res, PT);
    chk("release_next_lat", lat, 41);

    // Abort at round 5
    start_block(0, C1_CT);
    repeat (20) @(posedge Clk);
    #1;
    abort[0] = 1'b1;
    @(posedge Clk); #1;
    abort[0] = 1'b0;
    chk("abort_busy", busy[0], 1'b0);
    chk("abort_in_ready", in_ready[0], 1'b1);
    chk("abort_key_idx", key_idx[0], 128'd10);
    cnt = 0;
    repeat (60) begin
      @(posedge Clk); #1;
      if (out_valid[0]) cnt++;
    end
    chk("abort_out_valid_seen", cnt, 0);
    run(0, C1_CT, 1'b0, res, lat);
    chk("after_abort_data", res, PT);

    // abort in IDLE is ignored
    abort[0] = 1'b1;
    start_block(0, C1_CT);
    abort[0] = 1'b0;
    chk("idle_abort_busy", busy[0], 1'b1);
    wait_valid(0, lat, res);
    finish_block(0, 1'b0);
    chk("idle_abort_data", res, PT);

    // Reset mid-MIX
    start_block(1, C1_CT);
    repeat (6) @(posedge Clk);
    #3 Reset = 1'b1;
    #1 check_reset("rst_mix");
    #2 Reset = 1'b0;
    @(posedge Clk); #1;
    run(1, C1_CT, 1'b0, res, lat);
    chk("after_rst_mix_data", res, PT);

    // Reset during OUT
    out_ready[0] = 1'b0;
    start_block(0, C1_CT);
    wait_valid(0, lat, res);
    #3 Reset = 1'b1;
    #1 check_reset("rst_out");
    #2 Reset = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge Clk); #1;
    chk("after_rst_out_valid", out_valid[0], 1'b0);
    run(0, C1_CT, 1'b0, res, lat);
    chk("after_rst_out_data", res, PT);

    // Random back-to-back blocks with random output stalls
    stab_err = 0;
    for (int b = 0; b < 200; b++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      ct = encrypt(b % NI, pt);
      run(b % NI, ct, 1'b1, res, lat);
      chk($sformatf("rand_blk%0d_data", b), res, pt);
      chk($sformatf("rand_blk%0d_lat", b), lat,
          5 + (nr_of(b % NI) - 1) * (3 + 4 / cpc_of(b % NI)));
    end
    chk("rand_stall_unstable", stab_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
